gcd_handshake_engine: RTL and testbench

GCD_HANDSHAKE_ENGINE -- requirements
Module: gcd_handshake_engine

---
 rtl/gcd_pkg.sv | 13 +
 rtl/gcd_step.sv | 37 +++
 rtl/gcd_handshake_engine.sv | 155 +++++++++++++++
 tb/tb_gcd_handshake_engine.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD handshake engine.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    LCM  = 2'd2,
    DONE = 2'd3
  } gcd_state_e;

endpackage

// File: rtl/gcd_step.sv
// One compare/subtract step of the subtractive GCD algorithm (pure combinational).
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] b_next
);

  // Priority-ordered step: zero operands and equality terminate, otherwise subtract the smaller.
  always_comb begin
    done   = 1'b0;
    result = '0;
    a_next = a;
    b_next = b;
    if (a == '0) begin
      done   = 1'b1;
      result = b;
    end else if (b == '0) begin
      done   = 1'b1;
      result = a;
    end else if (a == b) begin
      done   = 1'b1;
      result = a;
    end else if (a > b) begin
      a_next = a - b;
    end else begin
      b_next = b - a;
    end
  end

endmodule

// File: rtl/gcd_handshake_engine.sv
// GCD engine with valid/ready handshakes on input and output.
// Optional LCM computation is enabled by defining macro GCD_LCM_EN.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand pair
// CALC  | one subtractive GCD step per cycle
// LCM   | repeated-addition LCM: acc += y_orig for each g in x_orig (GCD_LCM_EN only)
// DONE  | out_valid=1, holding results until out_ready
module gcd_handshake_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef GCD_LCM_EN
  output logic [2*WIDTH-1:0] out_lcm,
`endif
  output logic [WIDTH-1:0]   out_gcd
);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_gcd_q, out_gcd_d;

  logic             step_done;
  logic [WIDTH-1:0] step_result;
  logic [WIDTH-1:0] step_a_next;
  logic [WIDTH-1:0] step_b_next;

`ifdef GCD_LCM_EN
  logic [WIDTH-1:0]   x_orig_q, x_orig_d;
  logic [WIDTH-1:0]   y_orig_q, y_orig_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] out_lcm_q, out_lcm_d;
`endif

  gcd_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_q),
    .b      (b_q),
    .done   (step_done),
    .result (step_result),
    .a_next (step_a_next),
    .b_next (step_b_next)
  );

  // Next-state and datapath update; everything holds by default.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    out_gcd_d = out_gcd_q;
`ifdef GCD_LCM_EN
    x_orig_d  = x_orig_q;
    y_orig_d  = y_orig_q;
    r_d       = r_q;
    acc_d     = acc_q;
    out_lcm_d = out_lcm_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_x;
          b_d     = in_y;
`ifdef GCD_LCM_EN
          x_orig_d = in_x;
          y_orig_d = in_y;
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        if (step_done) begin
          out_gcd_d = step_result;
`ifdef GCD_LCM_EN
          // gcd 0 only arises from (0,0); LCM is defined as 0 and the divide loop is skipped.
          if (step_result == '0) begin
            out_lcm_d = '0;
            state_d   = DONE;
          end else begin
            r_d     = x_orig_q;
            acc_d   = '0;
            state_d = LCM;
          end
`else
          state_d = DONE;
`endif
        end else begin
          a_d = step_a_next;
          b_d = step_b_next;
        end
      end
`ifdef GCD_LCM_EN
      LCM: begin
        if (r_q >= out_gcd_q) begin
          r_d   = r_q - out_gcd_q;
          acc_d = acc_q + {{WIDTH{1'b0}}, y_orig_q};
        end else begin
          out_lcm_d = acc_q;
          state_d   = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      out_gcd_q <= '0;
`ifdef GCD_LCM_EN
      x_orig_q  <= '0;
      y_orig_q  <= '0;
      r_q       <= '0;
      acc_q     <= '0;
      out_lcm_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      out_gcd_q <= out_gcd_d;
`ifdef GCD_LCM_EN
      x_orig_q  <= x_orig_d;
      y_orig_q  <= y_orig_d;
      r_q       <= r_d;
      acc_q     <= acc_d;
      out_lcm_q <= out_lcm_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_gcd   = out_gcd_q;
`ifdef GCD_LCM_EN
  assign out_lcm   = out_lcm_q;
`endif

endmodule

// File: tb/tb_gcd_handshake_engine.sv
// Self-checking bench for gcd_handshake_engine; also exercises LCM when GCD_LCM_EN is defined.
module tb_gcd_handshake_engine;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_x;
  logic [W-1:0]   in_y;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_gcd;
`ifdef GCD_LCM_EN
  logic [2*W-1:0] out_lcm;
`endif

  int tests_run;
  int tests_failed;
  int unsigned last_gcd;
  int unsigned last_lcm;

  gcd_handshake_engine #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef GCD_LCM_EN
    .out_lcm   (out_lcm),
`endif
    .out_gcd   (out_gcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint unsigned obs, input longint unsigned exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: Euclid by division. The subtractive step count equals the sum of the
  // Euclidean quotients minus one (the final equal-operands step terminates instead).
  function automatic void model(input int unsigned x, input int unsigned y,
                                output int unsigned g, output int unsigned n);
    int unsigned a, b, t, s;
    if (x == 0) begin
      g = y; n = 0;
    end else if (y == 0) begin
      g = x; n = 0;
    end else begin
      a = x; b = y; s = 0;
      while (b != 0) begin
        s += a / b;
        t = a % b;
        a = b;
        b = t;
      end
      g = a;
      n = s - 1;
    end
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int unsigned x, input int unsigned y, input int hold);
    int unsigned g, n, exp_lat, exp_lcm;
    int lat;
    model(x, y, g, n);
    exp_lat = n + 1;
    exp_lcm = 0;
`ifdef GCD_LCM_EN
    if (g != 0) begin
      exp_lat += x / g + 1;
      exp_lcm = (x * y) / g;
    end
`endif
    lat = 0;
    while (!in_ready && lat < 1000) begin
      step();
      lat++;
    end
    check_eq("in_ready_before_accept", in_ready, 1);
    in_valid  = 1'b1;
    in_x      = x[W-1:0];
    in_y      = y[W-1:0];
    out_ready = (hold == 0);
    step();
    in_valid = 1'b0;
    in_x     = W'($urandom);
    in_y     = W'($urandom);
    check_eq("gcd_held_in_calc", out_gcd, last_gcd);
`ifdef GCD_LCM_EN
    check_eq("lcm_held_in_calc", out_lcm, last_lcm);
`endif
    lat = 0;
    while (!out_valid && lat < 2000) begin
      step();
      lat++;
    end
    check_eq("out_valid_rise", out_valid, 1);
    check_eq("latency", lat, exp_lat);
    check_eq("gcd_value", out_gcd, g);
`ifdef GCD_LCM_EN
    check_eq("lcm_value", out_lcm, exp_lcm);
`endif
    for (int i = 0; i < hold; i++) begin
      step();
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_gcd", out_gcd, g);
      check_eq("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    check_eq("post_hs_valid", out_valid, 0);
    check_eq("post_hs_in_ready", in_ready, 1);
    last_gcd = g;
    last_lcm = exp_lcm;
  endtask

  initial begin
    int unsigned q_g[$];
    int unsigned g, n;
    int accepts, results, guard;

    tests_run    = 0;
    tests_failed = 0;
    last_gcd     = 0;
    last_lcm     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b1;
    repeat (3) step();
    check_eq("reset_out_valid", out_valid, 0);
    check_eq("reset_out_gcd", out_gcd, 0);
    rst_n = 1'b1;
    step();
    check_eq("reset_in_ready", in_ready, 1);
`ifdef GCD_LCM_EN
    check_eq("reset_out_lcm", out_lcm, 0);
`endif

    // Directed cases.
    run_op(60, 65, 0);
    run_op(22, 22, 0);
    run_op(0, 54, 0);
    run_op(0, 0, 0);
    run_op(124, 48, 5);
    run_op(37, 0, 1);
`ifdef GCD_LCM_EN
    run_op(88, 77, 0);
    run_op(60, 65, 2);
`endif

    // Reset during CALC discards the operation.
    in_valid = 1'b1; in_x = 8'd255; in_y = 8'd1;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    check_eq("mid_calc_no_valid", out_valid, 0);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", out_valid, 0);
    check_eq("async_rst_gcd", out_gcd, 0);
    step();
    rst_n = 1'b1;
    last_gcd = 0;
    last_lcm = 0;
    guard = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (out_valid) guard++;
    end
    check_eq("no_valid_after_reset", guard, 0);
    run_op(63, 45, 0);

    // Random operands with random output stalls.
    for (int i = 0; i < 25; i++) begin
      run_op($urandom_range(0, 255), $urandom_range(0, 255), int'($urandom_range(0, 3)));
    end

    // Back-to-back: fresh operands every cycle, only the pair at an in_ready edge counts.
    accepts = 0;
    results = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (out_valid) begin
        if (q_g.size() == 0) check_eq("b2b_unexpected_result", 1, 0);
        else check_eq("b2b_gcd", out_gcd, q_g.pop_front());
        results++;
      end
      in_valid = 1'b1;
      in_x = W'($urandom_range(0, 40));
      in_y = W'($urandom_range(0, 40));
      if (in_ready) begin
        model(int'(in_x), int'(in_y), g, n);
        q_g.push_back(g);
        accepts++;
      end
      step();
    end
    in_valid = 1'b0;
    guard = 0;
    while (q_g.size() != 0 && guard < 2000) begin
      if (out_valid) begin
        check_eq("b2b_gcd_drain", out_gcd, q_g.pop_front());
        results++;
      end
      step();
      guard++;
    end
    check_eq("b2b_all_results", results, accepts);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
